// File: rtl/nios_system_mem_test_master.sv
// Avalon-MM memory test master: writes a seeded pattern over a wrapping word
// region, reads it back with pipelined reads, and counts mismatches.
module nios_system_mem_test_master #(
  parameter int WORD_AW  = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               verify_only,
  input  logic [WORD_AW-1:0] base_addr,
  input  logic [WORD_AW:0]   length,
  input  logic [31:0]        seed,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [WORD_AW:0]   err_count,
  output logic [WORD_AW-1:0] first_err_addr,
  output logic [WORD_AW+1:0] avm_address,
  output logic [3:0]         avm_byteenable,
  output logic               avm_read,
  output logic               avm_write,
  output logic [DATA_W-1:0]  avm_writedata,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_waitrequest,
  input  logic               avm_readdatavalid
);
  localparam int LW = WORD_AW + 1;
  localparam int PW = $clog2(MAX_PEND + 1);

  typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, FINISH} state_t;
  state_t state, state_nxt;

  logic [WORD_AW-1:0] base_q;
  logic [LW-1:0]      n_q, i_q, j_q, len_clamp;
  logic [31:0]        seed_q;
  logic [PW-1:0]      pend_q;
  logic               wr_acc, rd_acc, chk, mismatch, last_i;
  logic [WORD_AW-1:0] cur_addr;

  function automatic logic [31:0] pattern(input logic [31:0] s, input logic [LW-1:0] idx);
    logic [15:0] lo;
    lo = 16'(idx);
    return (s + 32'(idx)) ^ {lo, lo};
  endfunction

  // Lengths beyond the memory size collapse to one full pass
  assign len_clamp = (length[WORD_AW] && |length[WORD_AW-1:0]) ?
                     {1'b1, {WORD_AW{1'b0}}} : length;

  assign avm_byteenable = 4'hF;
  assign cur_addr = base_q + i_q[WORD_AW-1:0];
  assign last_i   = (i_q == n_q - LW'(1));
  assign wr_acc   = avm_write & ~avm_waitrequest;
  assign rd_acc   = avm_read & ~avm_waitrequest;
  // Returns outside an active verify phase (e.g. stragglers after reset) are dropped
  assign chk      = avm_readdatavalid && (state == READ || state == DRAIN) && (pend_q != '0);
  assign mismatch = chk && (avm_readdata != pattern(seed_q, j_q));

  always_comb begin
    state_nxt     = state;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (state)
      IDLE:
        if (start)
          state_nxt = (len_clamp == '0) ? FINISH : (verify_only ? READ : FILL);
      FILL: begin
        avm_write     = 1'b1;
        avm_address   = {cur_addr, 2'b00};
        avm_writedata = pattern(seed_q, i_q);
        if (!avm_waitrequest && last_i) state_nxt = READ;
      end
      READ: begin
        avm_address = {cur_addr, 2'b00};
        // Outstanding never rises while stalled, so a presented read stays held
        if (pend_q < PW'(MAX_PEND)) begin
          avm_read = 1'b1;
          if (!avm_waitrequest && last_i) state_nxt = DRAIN;
        end
      end
      DRAIN:
        if (pend_q == '0 && j_q == n_q) state_nxt = FINISH;
      FINISH:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      base_q         <= '0;
      n_q            <= '0;
      seed_q         <= '0;
      i_q            <= '0;
      j_q            <= '0;
      pend_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FINISH);
      if (state == FINISH) busy <= 1'b0;
      if (state == IDLE && start) begin
        base_q         <= base_addr;
        n_q            <= len_clamp;
        seed_q         <= seed;
        i_q            <= '0;
        j_q            <= '0;
        pend_q         <= '0;
        busy           <= 1'b1;
        error          <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        if (wr_acc) i_q <= last_i ? '0 : i_q + LW'(1);
        if (rd_acc) i_q <= i_q + LW'(1);
        if (chk)    j_q <= j_q + LW'(1);
        pend_q <= pend_q + PW'(rd_acc) - PW'(chk);
        if (mismatch) begin
          error <= 1'b1;
          if (!(&err_count)) err_count <= err_count + LW'(1);
          if (!error) first_err_addr <= base_q + j_q[WORD_AW-1:0];
        end
      end
    end
  end
endmodule
